// File: rtl/udp_tx_checksum_engine.sv
// UDP/IPv4 transmit stage: buffers one datagram payload in a FIFO while
// summing it, then emits the UDP header with the finished checksum
// followed by the stored payload.
module udp_tx_checksum_engine #(
  parameter int FIFO_DEPTH  = 256,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] local_ip,
  output logic        l4_ready,
  input  logic        l4_start,
  input  logic [31:0] l4_dst_ip,
  input  logic [15:0] l4_src_port,
  input  logic [15:0] l4_dst_port,
  input  logic [15:0] l4_payload_len,
  input  logic        l4_data_valid,
  input  logic [2:0]  l4_bytes_valid,
  input  logic [31:0] l4_data,
  input  logic        l4_commit,
  input  logic        l4_drop,
  output logic        l3_start,
  output logic        l3_commit,
  output logic        l3_drop,
  output logic [31:0] l3_dst_ip,
  output logic [15:0] l3_payload_len,
  output logic [7:0]  l3_protocol,
  output logic        l3_data_valid,
  output logic [2:0]  l3_bytes_valid,
  output logic [31:0] l3_data,
  output logic        err_overflow,
  output logic        err_length
);

  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] MAX_LEN   = 16'd65527;

  typedef enum logic [2:0] {IDLE, BUFFER, FOLD, HDR0, HDR1, BODY, COMMIT} state_t;

  state_t      state_reg, state_next;
  logic [15:0] src_port_reg, dst_port_reg, len_reg;
  logic [31:0] acc_reg, acc_next;
  logic [17:0] byte_cnt_reg, byte_cnt_next;
  logic [AW:0] wr_cnt_reg, wr_cnt_next, rd_ptr_reg, rd_ptr_next, rd_ptr_inc;
  logic [15:0] csum_reg, csum_next;
  logic        latch, push;
  logic [34:0] mem [FIFO_DEPTH];
  logic [34:0] rd_word;

  logic        start_next, commit_next, drop_next, dv_next, eovf_next, elen_next;
  logic [2:0]  bv_next;
  logic [31:0] data_next;

  logic [15:0] len8_in;
  logic [31:0] seed, masked, word_sum;
  logic [16:0] fold1;
  logic [15:0] fold2, csum_calc;

  // Bytes beyond bytes_valid must not contribute to the running sum.
  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [2:0] bv);
    case (bv)
      3'd1:    mask_bytes = d & 32'hFF00_0000;
      3'd2:    mask_bytes = d & 32'hFFFF_0000;
      3'd3:    mask_bytes = d & 32'hFFFF_FF00;
      default: mask_bytes = d;
    endcase
  endfunction

  // Arithmetic helpers: header seed, per-word sum and the final carry fold.
  always_comb begin
    len8_in   = l4_payload_len + 16'd8;
    seed      = 32'(local_ip[31:16]) + 32'(local_ip[15:0])
              + 32'(l4_dst_ip[31:16]) + 32'(l4_dst_ip[15:0]) + 32'h0000_0011
              + 32'(len8_in) + 32'(len8_in) + 32'(l4_src_port) + 32'(l4_dst_port);
    masked    = mask_bytes(l4_data, l4_bytes_valid);
    word_sum  = 32'(masked[31:16]) + 32'(masked[15:0]);
    fold1     = {1'b0, acc_reg[15:0]} + {1'b0, acc_reg[31:16]};
    fold2     = fold1[15:0] + 16'(fold1[16]);
    csum_calc = ~fold2;
    rd_ptr_inc = rd_ptr_reg + (AW+1)'(1);
  end

  // Next-state and next-output logic for the datagram sequencer.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    byte_cnt_next = byte_cnt_reg;
    wr_cnt_next   = wr_cnt_reg;
    rd_ptr_next   = rd_ptr_reg;
    csum_next     = csum_reg;
    latch         = 1'b0;
    push          = 1'b0;
    start_next    = 1'b0;
    commit_next   = 1'b0;
    drop_next     = 1'b0;
    dv_next       = 1'b0;
    bv_next       = 3'd0;
    data_next     = 32'd0;
    eovf_next     = 1'b0;
    elen_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (l4_start) begin
          if (l4_payload_len > MAX_LEN) begin
            elen_next = 1'b1;
          end else begin
            latch         = 1'b1;
            acc_next      = seed;
            byte_cnt_next = '0;
            wr_cnt_next   = '0;
            rd_ptr_next   = '0;
            state_next    = BUFFER;
          end
        end
      end
      BUFFER: begin
        if (l4_drop) begin
          wr_cnt_next = '0;
          state_next  = IDLE;
        end else if (l4_data_valid && wr_cnt_reg == DEPTH_CNT) begin
          eovf_next   = 1'b1;
          wr_cnt_next = '0;
          state_next  = IDLE;
        end else begin
          if (l4_data_valid) begin
            push          = 1'b1;
            acc_next      = acc_reg + word_sum;
            byte_cnt_next = byte_cnt_reg + 18'(l4_bytes_valid);
            wr_cnt_next   = wr_cnt_reg + (AW+1)'(1);
          end
          if (l4_commit) begin
            if (byte_cnt_next == {2'b00, len_reg}) begin
              state_next = FOLD;
            end else begin
              elen_next   = 1'b1;
              wr_cnt_next = '0;
              state_next  = IDLE;
            end
          end
        end
      end
      FOLD: begin
        if (l4_drop) begin
          state_next = IDLE;
        end else begin
          // A computed zero is transmitted as all-ones; zero means "no checksum".
          if (CHECKSUM_EN) csum_next = (csum_calc == 16'h0000) ? 16'hFFFF : csum_calc;
          else             csum_next = 16'h0000;
          start_next = 1'b1;
          state_next = HDR0;
        end
      end
      HDR0: begin
        if (l4_drop) begin
          drop_next  = 1'b1;
          state_next = IDLE;
        end else begin
          dv_next    = 1'b1;
          bv_next    = 3'd4;
          data_next  = {src_port_reg, dst_port_reg};
          state_next = HDR1;
        end
      end
      HDR1: begin
        if (l4_drop) begin
          drop_next  = 1'b1;
          state_next = IDLE;
        end else begin
          dv_next    = 1'b1;
          bv_next    = 3'd4;
          data_next  = {l3_payload_len, csum_reg};
          state_next = (wr_cnt_reg == '0) ? COMMIT : BODY;
        end
      end
      BODY: begin
        if (l4_drop) begin
          drop_next  = 1'b1;
          state_next = IDLE;
        end else begin
          dv_next     = 1'b1;
          bv_next     = rd_word[34:32];
          data_next   = rd_word[31:0];
          rd_ptr_next = rd_ptr_inc;
          if (rd_ptr_inc == wr_cnt_reg) state_next = COMMIT;
        end
      end
      COMMIT: begin
        if (l4_drop) drop_next   = 1'b1;
        else         commit_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datagram context, running sum and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg      <= '0;
      byte_cnt_reg <= '0;
      wr_cnt_reg   <= '0;
      rd_ptr_reg   <= '0;
      csum_reg     <= '0;
      src_port_reg <= '0;
      dst_port_reg <= '0;
      len_reg      <= '0;
    end else begin
      acc_reg      <= acc_next;
      byte_cnt_reg <= byte_cnt_next;
      wr_cnt_reg   <= wr_cnt_next;
      rd_ptr_reg   <= rd_ptr_next;
      csum_reg     <= csum_next;
      if (latch) begin
        src_port_reg <= l4_src_port;
        dst_port_reg <= l4_dst_port;
        len_reg      <= l4_payload_len;
      end
    end
  end

  // Registered outputs toward the application and IPv4 TX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l4_ready       <= 1'b1;
      l3_start       <= 1'b0;
      l3_commit      <= 1'b0;
      l3_drop        <= 1'b0;
      l3_dst_ip      <= '0;
      l3_payload_len <= '0;
      l3_protocol    <= '0;
      l3_data_valid  <= 1'b0;
      l3_bytes_valid <= '0;
      l3_data        <= '0;
      err_overflow   <= 1'b0;
      err_length     <= 1'b0;
    end else begin
      l4_ready       <= (state_next == IDLE);
      l3_start       <= start_next;
      l3_commit      <= commit_next;
      l3_drop        <= drop_next;
      l3_data_valid  <= dv_next;
      l3_bytes_valid <= bv_next;
      l3_data        <= data_next;
      err_overflow   <= eovf_next;
      err_length     <= elen_next;
      if (latch) begin
        l3_dst_ip      <= l4_dst_ip;
        l3_payload_len <= len8_in;
        l3_protocol    <= 8'h11;
      end
    end
  end

  // Payload buffer; the read register prefetches the word BODY sends next.
  always_ff @(posedge clk) begin
    if (push) mem[wr_cnt_reg[AW-1:0]] <= {l4_bytes_valid, l4_data};
    rd_word <= mem[rd_ptr_next[AW-1:0]];
  end

endmodule

// File: tb/tb_udp_tx_checksum_engine.sv
// Bench for udp_tx_checksum_engine: two instances (checksum on / off) driven
// in lockstep, a vector table of datagrams, and per-instance scoreboards
// of expected L3 events tagged with the exact cycle they must appear in.
module tb_udp_tx_checksum_engine;

  localparam logic [31:0] LOCAL_IP = 32'h0A00_0001;
  localparam logic [2:0] K_START = 3'd1, K_WORD = 3'd2, K_COMMIT = 3'd3,
                         K_DROP = 3'd4, K_EOVF = 3'd5, K_ELEN = 3'd6;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] cyc;
    logic [31:0] data;
    logic [2:0]  bv;
    logic [15:0] len;
    logic [7:0]  proto;
  } ev_t;

  // res: 0 ok, 1 bad length at start, 2 bad length at commit, 3 overflow
  typedef struct packed {
    logic [15:0]      len;
    logic [15:0]      sp;
    logic [15:0]      dp;
    logic [31:0]      dip;
    logic [2:0]       n;
    logic [4:0][31:0] w;
    logic [4:0][2:0]  b;
    logic             csep;
    logic [1:0]       res;
    logic [31:0]      hdr1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, dv = 1'b0, commit = 1'b0, drop = 1'b0;
  logic [31:0] dip = '0, din = '0;
  logic [15:0] sp = '0, dp = '0, plen = '0;
  logic [2:0]  bvin = '0;
  logic [31:0] lip = LOCAL_IP;

  logic        o_ready [2], o_start [2], o_commit [2], o_drop [2];
  logic        o_dv [2], o_eovf [2], o_elen [2];
  logic [31:0] o_dst [2], o_data [2];
  logic [15:0] o_plen [2];
  logic [7:0]  o_proto [2];
  logic [2:0]  o_bv [2];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  qa[$];
  ev_t  qb[$];
  vec_t vecs [10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udp_tx_checksum_engine #(.FIFO_DEPTH(4), .CHECKSUM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .local_ip(lip), .l4_ready(o_ready[0]),
    .l4_start(start), .l4_dst_ip(dip), .l4_src_port(sp), .l4_dst_port(dp),
    .l4_payload_len(plen), .l4_data_valid(dv), .l4_bytes_valid(bvin),
    .l4_data(din), .l4_commit(commit), .l4_drop(drop),
    .l3_start(o_start[0]), .l3_commit(o_commit[0]), .l3_drop(o_drop[0]),
    .l3_dst_ip(o_dst[0]), .l3_payload_len(o_plen[0]), .l3_protocol(o_proto[0]),
    .l3_data_valid(o_dv[0]), .l3_bytes_valid(o_bv[0]), .l3_data(o_data[0]),
    .err_overflow(o_eovf[0]), .err_length(o_elen[0])
  );

  udp_tx_checksum_engine #(.FIFO_DEPTH(4), .CHECKSUM_EN(1'b0)) dut_nocsum (
    .clk(clk), .rst(rst), .local_ip(lip), .l4_ready(o_ready[1]),
    .l4_start(start), .l4_dst_ip(dip), .l4_src_port(sp), .l4_dst_port(dp),
    .l4_payload_len(plen), .l4_data_valid(dv), .l4_bytes_valid(bvin),
    .l4_data(din), .l4_commit(commit), .l4_drop(drop),
    .l3_start(o_start[1]), .l3_commit(o_commit[1]), .l3_drop(o_drop[1]),
    .l3_dst_ip(o_dst[1]), .l3_payload_len(o_plen[1]), .l3_protocol(o_proto[1]),
    .l3_data_valid(o_dv[1]), .l3_bytes_valid(o_bv[1]), .l3_data(o_data[1]),
    .err_overflow(o_eovf[1]), .err_length(o_elen[1])
  );

  function automatic ev_t mk(input logic [2:0] k, input int c, input logic [31:0] d,
                             input logic [2:0] b, input logic [15:0] l, input logic [7:0] p);
    ev_t e;
    e.kind = k; e.cyc = 32'(c); e.data = d; e.bv = b; e.len = l; e.proto = p;
    return e;
  endfunction

  // Reference UDP checksum over pseudo-header, UDP header and masked payload.
  function automatic logic [15:0] ref_csum(input vec_t v);
    logic [31:0] s, m, li;
    logic [15:0] l8, r;
    li = LOCAL_IP;
    l8 = v.len + 16'd8;
    s = 32'(li[31:16]) + 32'(li[15:0]) + 32'(v.dip[31:16]) + 32'(v.dip[15:0])
      + 32'h11 + 32'(l8) + 32'(l8) + 32'(v.sp) + 32'(v.dp);
    for (int i = 0; i < 32'(v.n); i++) begin
      m = v.w[i] & ~(32'hFFFF_FFFF >> (8 * int'(v.b[i])));
      s = s + 32'(m[31:16]) + 32'(m[15:0]);
    end
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    r = ~s[15:0];
    if (r == 16'h0) r = 16'hFFFF;
    return r;
  endfunction

  task automatic set_vec(input int idx, input logic [15:0] len, input logic [15:0] s_p,
                         input logic [15:0] d_p, input logic [31:0] d_ip, input logic [2:0] n,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4,
                         input logic [2:0] b0, input logic [2:0] b1, input logic [2:0] b2,
                         input logic [2:0] b3, input logic [2:0] b4,
                         input logic csep, input logic [1:0] res, input logic [31:0] hdr1);
    vec_t v;
    v.len = len; v.sp = s_p; v.dp = d_p; v.dip = d_ip; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.csep = csep; v.res = res; v.hdr1 = hdr1;
    vecs[idx] = v;
  endtask

  task automatic push2(input logic [2:0] k, input int c, input logic [31:0] da,
                       input logic [31:0] db, input logic [2:0] b, input logic [15:0] l,
                       input logic [7:0] p);
    qa.push_back(mk(k, c, da, b, l, p));
    qb.push_back(mk(k, c, db, b, l, p));
  endtask

  task automatic check_evt(input int u, input ev_t got);
    ev_t ex;
    bit  empty;
    empty = (u == 0) ? (qa.size() == 0) : (qb.size() == 0);
    checks++;
    if (empty) begin
      failures++;
      $display("FAIL unit%0d unexpected_event got kind=%0d cyc=%0d data=%h required none",
               u, got.kind, got.cyc, got.data);
    end else begin
      if (u == 0) ex = qa.pop_front();
      else        ex = qb.pop_front();
      if (got !== ex)begin
        failures++;
        $display("FAIL unit%0d l3_event got kind=%0d cyc=%0d data=%h bv=%0d len=%0d proto=%h required kind=%0d cyc=%0d data=%h bv=%0d len=%0d proto=%h",
                 u, got.kind, got.cyc, got.data, got.bv, got.len, got.proto,
                 ex.kind, ex.cyc, ex.data, ex.bv, ex.len, ex.proto);
      end
    end
  endtask

  // Output monitor: every L3 pulse, word and error strobe is matched in order.
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        if (o_start[u])  check_evt(u, mk(K_START, cyc, o_dst[u], 3'd0, o_plen[u], o_proto[u]));
        if (o_dv[u])     check_evt(u, mk(K_WORD, cyc, o_data[u], o_bv[u], 16'd0, 8'd0));
        if (o_commit[u]) check_evt(u, mk(K_COMMIT, cyc, 32'd0, 3'd0, 16'd0, 8'd0));
        if (o_drop[u])   check_evt(u, mk(K_DROP, cyc, 32'd0, 3'd0, 16'd0, 8'd0));
        if (o_eovf[u])   check_evt(u, mk(K_EOVF, cyc, 32'd0, 3'd0, 16'd0, 8'd0));
        if (o_elen[u])   check_evt(u, mk(K_ELEN, cyc, 32'd0, 3'd0, 16'd0, 8'd0));
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!(o_ready[0] && o_ready[1]) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (!(o_ready[0] && o_ready[1])) begin
      failures++;
      $display("FAIL ready_timeout got ready=%b%b required 11", o_ready[0], o_ready[1]);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d/%0d required 0/0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  // Drives one datagram; nedge is the clock edge that samples its final event.
  task automatic drive_dgram(input vec_t v, output int nedge);
    start = 1'b1; dip = v.dip; sp = v.sp; dp = v.dp; plen = v.len;
    nedge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.res == 2'd1) return;
    for (int i = 0; i < 32'(v.n); i++) begin
      dv = 1'b1; din = v.w[i]; bvin = v.b[i];
      commit = (!v.csep && i == 32'(v.n) - 1 && v.res != 2'd3);
      nedge = cyc + 1;
      @(posedge clk); #1;
      dv = 1'b0; commit = 1'b0;
    end
    if (v.res == 2'd3) return;
    if (v.csep || v.n == 3'd0) begin
      commit = 1'b1;
      nedge = cyc + 1;
      @(posedge clk); #1;
      commit = 1'b0;
    end
  endtask

  task automatic expect_dgram(input vec_t v, input int n, input int nw, input bit dropped);
    logic [15:0] l8;
    logic [31:0] h1;
    l8 = v.len + 16'd8;
    h1 = (v.hdr1 != 32'd0) ? v.hdr1 : {l8, ref_csum(v)};
    if (v.res == 2'd1 || v.res == 2'd2) begin
      push2(K_ELEN, n, 32'd0, 32'd0, 3'd0, 16'd0, 8'd0);
    end else if (v.res == 2'd3) begin
      push2(K_EOVF, n, 32'd0, 32'd0, 3'd0, 16'd0, 8'd0);
    end else begin
      push2(K_START, n + 1, v.dip, v.dip, 3'd0, l8, 8'h11);
      push2(K_WORD, n + 2, {v.sp, v.dp}, {v.sp, v.dp}, 3'd4, 16'd0, 8'd0);
      push2(K_WORD, n + 3, h1, {l8, 16'h0000}, 3'd4, 16'd0, 8'd0);
      for (int i = 0; i < nw; i++)
        push2(K_WORD, n + 4 + i, v.w[i], v.w[i], v.b[i], 16'd0, 8'd0);
      if (dropped) push2(K_DROP, n + 4 + nw, 32'd0, 32'd0, 3'd0, 16'd0, 8'd0);
      else         push2(K_COMMIT, n + 4 + nw, 32'd0, 32'd0, 3'd0, 16'd0, 8'd0);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   n;
    v = vecs[idx];
    wait_ready();
    drive_dgram(v, n);
    expect_dgram(v, n, int'(v.n), 1'b0);
    $display("TB txn vec=%0d len=%0d words=%0d res=%0d edge=%0d", idx, v.len, v.n, v.res, n);
    if (v.res == 2'd3) begin
      @(negedge clk);
      checks++;
      if (o_ready[0] !== 1'b1) begin
        failures++;
        $display("FAIL ovf_ready got %b required 1", o_ready[0]);
      end
    end
    wait_drain();
  endtask

  initial begin
    int n;
    //       idx len     sp        dp        dip           n  words                                                              bytes                   csep res  hdr1
    set_vec(0, 16'd4,  16'h1234, 16'h0035, 32'h0A000002, 3'd1, 32'h61626364, 32'h0, 32'h0, 32'h0, 32'h0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 32'h000C14A4);
    set_vec(1, 16'd5,  16'h1234, 16'h0035, 32'h0A000002, 3'd2, 32'h61626364, 32'h65000000, 32'h0, 32'h0, 32'h0, 3'd4, 3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 2'd0, 32'h000DAFA1);
    set_vec(2, 16'd0,  16'h0007, 16'h0009, 32'h0A000002, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd0, 32'h0);
    set_vec(3, 16'd16, 16'hFFFF, 16'h0001, 32'hC0A80105, 3'd4, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 1'b1, 2'd0, 32'h0);
    set_vec(4, 16'd8,  16'h1234, 16'h0035, 32'h0A000002, 3'd1, 32'h11112222, 32'h0, 32'h0, 32'h0, 32'h0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'd2, 32'h0);
    set_vec(5, 16'd7,  16'h0400, 16'h0401, 32'h0A000002, 3'd3, 32'hAABBCCDD, 32'h11223344, 32'h5566FFFF, 32'h0, 32'h0, 3'd2, 3'd3, 3'd2, 3'd0, 3'd0, 1'b0, 2'd0, 32'h0);
    set_vec(6, 16'd20, 16'h1234, 16'h0035, 32'h0A000002, 3'd5, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h05050505, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 1'b0, 2'd3, 32'h0);
    set_vec(7, 16'd65528, 16'h1234, 16'h0035, 32'h0A000002, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd1, 32'h0);
    set_vec(8, 16'd4,  16'h1234, 16'h0035, 32'h0A000002, 3'd1, 32'hD96A0000, 32'h0, 32'h0, 32'h0, 32'h0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0, 32'h000CFFFF);
    set_vec(9, 16'd12, 16'h2000, 16'h3000, 32'h0A000002, 3'd3, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 1'b0, 2'd0, 32'h0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (o_ready[u] !== 1'b1 ||
          {o_start[u], o_commit[u], o_drop[u], o_dst[u], o_plen[u], o_proto[u],
           o_dv[u], o_bv[u], o_data[u], o_eovf[u], o_elen[u]} !== '0) begin
        failures++;
        $display("FAIL unit%0d reset_state got ready=%b data=%h plen=%h required ready=1 all else 0",
                 u, o_ready[u], o_data[u], o_plen[u]);
      end
    end

    for (int i = 0; i < 9; i++) run_vec(i);

    // Drop while the second payload word is due: l3_drop replaces it.
    wait_ready();
    drive_dgram(vecs[9], n);
    expect_dgram(vecs[9], n, 1, 1'b1);
    repeat (4) @(posedge clk);
    #1 drop = 1'b1;
    @(posedge clk); #1 drop = 1'b0;
    $display("TB txn body_drop edge=%0d", n);
    wait_drain();
    run_vec(0);

    // Largest legal length accepted, then dropped while buffering: silent.
    wait_ready();
    start = 1'b1; plen = 16'd65527; dip = 32'h0A000002; sp = 16'h1; dp = 16'h2;
    @(posedge clk); #1 start = 1'b0;
    dv = 1'b1; din = 32'h01020304; bvin = 3'd4;
    @(posedge clk); #1 dv = 1'b0; drop = 1'b1;
    @(posedge clk); #1 drop = 1'b0;
    repeat (6) @(posedge clk);
    $display("TB txn buffer_drop len=65527");
    wait_ready();

    // Reset in the middle of buffering: back to idle without any pulse.
    start = 1'b1; plen = 16'd8;
    @(posedge clk); #1 start = 1'b0;
    dv = 1'b1; din = 32'h0A0B0C0D; bvin = 3'd4;
    @(posedge clk); #1 dv = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ready[0] !== 1'b1 || o_ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready got %b%b required 11", o_ready[0], o_ready[1]);
    end
    $display("TB txn mid_reset");
    run_vec(1);
    run_vec(5);

    repeat (5) @(posedge clk);
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
